// File: rtl/pc_fetch_unit.sv
// PC / instruction-fetch stage feeding the 16-bit imem and the decode register.
// Optional FETCH_COUNT_EN adds o_fetch_cnt, a saturating count of sequential captures.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] PC_STEP    = 16'd2,
    parameter int          IMEM_DEPTH = 15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_branch_en,
    input  logic [15:0] i_branch_off,
    input  logic        i_jump_en,
    input  logic [15:0] i_jump_target,
    input  logic [15:0] i_InstrData,
    output logic [15:0] o_Addr,
    output logic [15:0] o_instr,
    output logic        o_instr_valid,
    output logic [15:0] o_pc_plus2,
`ifdef FETCH_COUNT_EN
    output logic [15:0] o_fetch_cnt,
`endif
    output logic        o_halted
);

    localparam logic [15:0] LAST_PC = 16'(2 * (IMEM_DEPTH - 1));

    typedef enum logic {FETCH, HALT} state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] instr_n;
    logic [15:0] pc_plus2_n;
    logic        valid_n;
    logic        capture;

    assign o_Addr   = pc;
    assign o_halted = (state == HALT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            o_instr       <= 16'h0000;
            o_instr_valid <= 1'b0;
            o_pc_plus2    <= 16'h0000;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            o_instr       <= instr_n;
            o_instr_valid <= valid_n;
            o_pc_plus2    <= pc_plus2_n;
        end
    end

    // Redirects only count when they come from a live instruction.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = o_instr;
        pc_plus2_n = o_pc_plus2;
        valid_n    = o_instr_valid;
        capture    = 1'b0;
        unique case (state)
            FETCH: begin
                if (o_instr_valid && i_jump_en) begin
                    pc_n    = i_jump_target & 16'hFFFE;
                    valid_n = 1'b0;
                end else if (o_instr_valid && i_branch_en) begin
                    pc_n    = o_pc_plus2 + (i_branch_off << 1);
                    valid_n = 1'b0;
                end else if (i_stall) begin
                    pc_n = pc;
                end else if (pc > LAST_PC) begin
                    state_n = HALT;
                    valid_n = 1'b0;
                end else begin
                    capture    = 1'b1;
                    instr_n    = i_InstrData;
                    pc_plus2_n = pc + PC_STEP;
                    valid_n    = 1'b1;
                    pc_n       = pc + PC_STEP;
                end
            end
            HALT: begin
                state_n = HALT;
            end
        endcase
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_fetch_cnt <= 16'h0000;
        else if (capture && o_fetch_cnt != 16'hFFFF)
            o_fetch_cnt <= o_fetch_cnt + 16'd1;
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, redirects, stall, halt, async reset.
module tb_pc_fetch_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_stall;
    logic        i_branch_en;
    logic [15:0] i_branch_off;
    logic        i_jump_en;
    logic [15:0] i_jump_target;
    logic [15:0] i_InstrData;
    logic [15:0] o_Addr;
    logic [15:0] o_instr;
    logic        o_instr_valid;
    logic [15:0] o_pc_plus2;
    logic        o_halted;
`ifdef FETCH_COUNT_EN
    logic [15:0] o_fetch_cnt;
`endif

    int vectors;
    int miscompares;
    logic [15:0] rom [16];

    pc_fetch_unit dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_branch_en   (i_branch_en),
        .i_branch_off  (i_branch_off),
        .i_jump_en     (i_jump_en),
        .i_jump_target (i_jump_target),
        .i_InstrData   (i_InstrData),
        .o_Addr        (o_Addr),
        .o_instr       (o_instr),
        .o_instr_valid (o_instr_valid),
        .o_pc_plus2    (o_pc_plus2),
`ifdef FETCH_COUNT_EN
        .o_fetch_cnt   (o_fetch_cnt),
`endif
        .o_halted      (o_halted)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    assign i_InstrData = rom[o_Addr[4:1]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] a, input logic [15:0] ins,
                           input logic [15:0] p2, input logic v, input logic h);
        chk({tag, ".addr"}, o_Addr, a);
        chk({tag, ".instr"}, o_instr, ins);
        chk({tag, ".pc_plus2"}, o_pc_plus2, p2);
        chk({tag, ".valid"}, {15'd0, o_instr_valid}, {15'd0, v});
        chk({tag, ".halted"}, {15'd0, o_halted}, {15'd0, h});
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef FETCH_COUNT_EN
        chk(tag, o_fetch_cnt, exp);
`else
        if (tag.len() == 0) $display("empty tag %h", exp);
`endif
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_stall = 0;
        i_branch_en = 0;
        i_branch_off = 0;
        i_jump_en = 0;
        i_jump_target = 0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        rom[2] = 16'h3333;
        rom[3] = 16'h4444;
        for (int k = 4; k < 15; k++) rom[k] = 16'hA000 | 16'(k);
        rom[15] = 16'hDEAD;
        idle();
        i_rst = 1;
        #2;
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 0, 0);
        chk_cnt("reset.cnt", 16'd0);
        #1 i_rst = 0;

        step(); chk_all("seq1", 16'd2, 16'h1111, 16'd2, 1, 0);
        step(); chk_all("seq2", 16'd4, 16'h2222, 16'd4, 1, 0);

        i_branch_en = 1; i_branch_off = 16'hFFFE;
        step(); chk_all("branch", 16'd0, 16'h2222, 16'd4, 0, 0);
        i_branch_off = 16'h0008;
        step(); chk_all("branch_ignored", 16'd2, 16'h1111, 16'd2, 1, 0);

        i_jump_en = 1; i_jump_target = 16'h0015; i_stall = 1;
        step(); chk_all("jump_over_branch", 16'h0014, 16'h1111, 16'd2, 0, 0);
        idle();
        step(); chk_all("jump_target", 16'd22, 16'hA00A, 16'd22, 1, 0);

        i_jump_en = 1; i_jump_target = 16'h0006; i_stall = 1;
        step(); chk_all("jump_in_stall", 16'd6, 16'hA00A, 16'd22, 0, 0);
        i_jump_en = 0;
        step(); chk_all("stall_invalid", 16'd6, 16'hA00A, 16'd22, 0, 0);
        i_stall = 0;
        step(); chk_all("resume6", 16'd8, 16'h4444, 16'd8, 1, 0);
        chk_cnt("cnt5", 16'd5);

        i_stall = 1;
        for (int k = 0; k < 3; k++) begin
            step(); chk_all("stall_valid", 16'd8, 16'h4444, 16'd8, 1, 0);
        end
        i_stall = 0;
        step(); chk_all("resume8", 16'd10, 16'hA004, 16'd10, 1, 0);

        for (int p = 10; p <= 28; p += 2) begin
            step();
            chk_all("run", 16'(p + 2), 16'hA000 | 16'(p / 2), 16'(p + 2), 1, 0);
        end
        step(); chk_all("halt", 16'd30, 16'hA00E, 16'd30, 0, 1);
        chk_cnt("cnt_halt", 16'd16);
        i_jump_en = 1; i_jump_target = 16'h0000; i_branch_en = 1;
        step(); chk_all("halt_jump", 16'd30, 16'hA00E, 16'd30, 0, 1);
        idle();
        step(); chk_all("halt_hold", 16'd30, 16'hA00E, 16'd30, 0, 1);

        i_rst = 1;
        #2;
        chk_all("reset_halt", 16'd0, 16'h0000, 16'h0000, 0, 0);
        i_rst = 0;
        for (int k = 0; k < 5; k++) step();
        chk_all("rerun", 16'd10, 16'hA004, 16'd10, 1, 0);
        chk_cnt("cnt_rerun", 16'd5);
        i_stall = 1;
        step(); chk_all("stall10", 16'd10, 16'hA004, 16'd10, 1, 0);
        #2 i_rst = 1;
        #1;
        chk_all("async_reset", 16'd0, 16'h0000, 16'h0000, 0, 0);
        chk_cnt("async_reset.cnt", 16'd0);
        i_rst = 0;
        idle();
        step(); chk_all("post_reset", 16'd2, 16'h1111, 16'd2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
